tb_req_responder: RTL and testbench
===================================

TB_REQ_RESPONDER -- requirements
Module: tb_req_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, request/response data width.
REQ-002 SHALL have parameter ADDR_W, default 4, register address width.
REQ-003 SHALL have parameter NUM_REGS, default 12, implemented registers (1..2**ADDR_W).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, response FIFO entries (power of 2, >=2).
REQ-005 SHALL have ports, one per line:
- tb_clk  in  1  single clock; all logic on rising edge.
- tb_rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder accepts request this cycle.
- req_op  in  2  00 read, 01 write, 10 increment, 11 reserved.
- req_id  in  4  transaction tag.
- req_addr  in  ADDR_W  register index.
- req_data  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  4  echoed tag.
- rsp_data  out  DATA_W  read/old data.
- rsp_status  out  2  00 OK, 01 illegal op, 10 address error.
- err_cnt  out  8  saturating count of non-OK responses.

Function
REQ-006 SHALL accept a request on any edge where req_valid && req_ready; otherwise it SHALL NOT accept.
REQ-007 SHALL drive req_ready = 1 iff response FIFO count < FIFO_DEPTH; a same-cycle pop SHALL NOT raise req_ready (no fall-through).
REQ-008 Read SHALL push {id, reg[addr], OK}; register unchanged.
REQ-009 Write SHALL update reg[addr] <= req_data at the accept edge and SHALL push {id, req_data, OK}.
REQ-010 Increment SHALL push {id, old reg[addr], OK} and set reg[addr] <= old+1 modulo 2**DATA_W (0xFFFFFFFF -> 0).
REQ-011 Op 11 SHALL push {id, 0, 01}, with no register change.
REQ-012 Each accepted request SHALL push exactly one FIFO entry at its accept edge; rsp_valid SHALL assert no earlier than the following cycle (1-cycle minimum latency).
REQ-013 Responses SHALL leave in acceptance order; an entry pops on rsp_valid && rsp_ready.
REQ-014 rsp_id/rsp_data/rsp_status SHALL hold stable while rsp_valid && !rsp_ready.
REQ-015 Simultaneous push and pop SHALL leave the count unchanged; a push when full SHALL NOT occur by construction.
REQ-016 A read, write or increment one cycle after a write to the same address SHALL observe the written value.
REQ-017 err_cnt SHALL increment by 1 per pushed non-OK response and SHALL saturate at 255.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-019 When tb_rst = 1 at an edge: all registers 0, FIFO emptied, err_cnt 0, rsp_valid 0, rsp_id/rsp_data/rsp_status 0.
REQ-020 req_ready SHALL be 0 during reset cycles and 1 on the first cycle after reset deasserts.
REQ-021 Reset mid-operation SHALL discard every queued response; a request presented in a reset cycle SHALL NOT be accepted.

Configuration
REQ-022 Macro TB_RSP_ADDR_CHK_EN SHALL control the address range check.
REQ-023 With TB_RSP_ADDR_CHK_EN defined, any non-reserved op with req_addr >= NUM_REGS SHALL push {id, 0, 10}, with no register change, counted in err_cnt.
REQ-024 Without TB_RSP_ADDR_CHK_EN, such accesses SHALL return status OK and data 0, and writes and increments SHALL be ignored.

Verification
REQ-025 Reset, then write addr 3 = 0xDEADBEEF, then read addr 3 -> responses (id0, 0xDEADBEEF, 00), (id1, 0xDEADBEEF, 00) in order.
REQ-026 Write addr 5 = 0xFFFFFFFF, then increment addr 5, then read addr 5 -> increment returns 0xFFFFFFFF and the read returns 0x00000000.
REQ-027 Hold rsp_ready = 0 and issue 5 reads with FIFO_DEPTH = 4 -> req_ready drops after the 4th accept; raise rsp_ready -> 4 responses, then the 5th accepted and returned.
REQ-028 Op 11 with id 0xA -> (0xA, 0, 01) and err_cnt = 1; 300 op-11 requests -> err_cnt = 255.
REQ-029 Read addr 13 with NUM_REGS = 12 -> status 10 with macro, status 00 data 0 without; write addr 13 leaves no observable state.
REQ-030 Queue 3 responses, assert tb_rst for 1 cycle -> rsp_valid 0 next cycle, err_cnt 0, a read of any written register returns 0.

Source files
------------

// File: rtl/tb_req_responder.sv
// Register-file request responder: read/write/increment requests answered through an in-order response FIFO.
// Optional feature: define TB_RSP_ADDR_CHK_EN to report addresses >= NUM_REGS with status 10.
module tb_req_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int NUM_REGS   = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              tb_clk,
  input  logic              tb_rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [3:0]        req_id,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [3:0]        rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic [7:0]        err_cnt
);

  // Handshakes: a request is taken on an edge where req_valid && req_ready,
  // a response leaves on an edge where rsp_valid && rsp_ready; neither side
  // may depend combinationally on the other side's ready.

  localparam int              PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] NREG_C  = (ADDR_W+1)'(NUM_REGS);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_ILL  = 2'b01;
  localparam logic [1:0] ST_ADDR = 2'b10;

  logic [DATA_W-1:0] r_regs  [NUM_REGS];
  logic [3:0]        r_fid   [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fdata [FIFO_DEPTH];
  logic [1:0]        r_fstat [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [7:0]        r_err;

  logic              w_push;
  logic              w_pop;
  logic              w_in_range;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_rsp_data;
  logic [1:0]        w_rsp_stat;
  logic              w_reg_we;
  logic [DATA_W-1:0] w_reg_wdata;

  // No fall-through: ready depends only on the registered count.
  assign req_ready  = !tb_rst && (r_count < DEPTH_C);
  assign rsp_valid  = (r_count != '0);
  assign w_push     = req_valid && req_ready;
  assign w_pop      = rsp_valid && rsp_ready;
  assign w_in_range = ({1'b0, req_addr} < NREG_C);
  assign w_old      = w_in_range ? r_regs[req_addr] : '0;

  always_comb begin
    w_rsp_data  = '0;
    w_rsp_stat  = ST_OK;
    w_reg_we    = 1'b0;
    w_reg_wdata = w_old;
    if (req_op == 2'b11) begin
      w_rsp_stat = ST_ILL;
    end else if (!w_in_range) begin
`ifdef TB_RSP_ADDR_CHK_EN
      w_rsp_stat = ST_ADDR;
`else
      w_rsp_stat = ST_OK;
`endif
    end else begin
      case (req_op)
        OP_RD: w_rsp_data = w_old;
        OP_WR: begin
          w_rsp_data  = req_data;
          w_reg_we    = 1'b1;
          w_reg_wdata = req_data;
        end
        OP_INC: begin
          w_rsp_data  = w_old;
          w_reg_we    = 1'b1;
          w_reg_wdata = w_old + DATA_W'(1);
        end
        default: w_rsp_data = '0;
      endcase
    end
  end

  always_ff @(posedge tb_clk) begin
    if (tb_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= '0;
    end else begin
      if (w_push && w_reg_we) r_regs[req_addr] <= w_reg_wdata;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && (w_rsp_stat != ST_OK) && (r_err != 8'hFF)) r_err <= r_err + 1'b1;
    end
  end

  // Entry storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge tb_clk) begin
    if (w_push) begin
      r_fid[r_wr_ptr]   <= req_id;
      r_fdata[r_wr_ptr] <= w_rsp_data;
      r_fstat[r_wr_ptr] <= w_rsp_stat;
    end
  end

  assign rsp_id     = rsp_valid ? r_fid[r_rd_ptr]   : '0;
  assign rsp_data   = rsp_valid ? r_fdata[r_rd_ptr] : '0;
  assign rsp_status = rsp_valid ? r_fstat[r_rd_ptr] : '0;
  assign err_cnt    = r_err;

endmodule

// File: tb/tb_tb_req_responder.sv
// Bench for tb_req_responder: queue-based reference model checked every cycle, plus directed literal checks.
module tb_tb_req_responder;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NR = 12;
  localparam int FD = 4;

`ifdef TB_RSP_ADDR_CHK_EN
  localparam logic [1:0] ST_OOR = 2'b10;
`else
  localparam logic [1:0] ST_OOR = 2'b00;
`endif

  logic          tb_clk = 1'b0;
  logic          tb_rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [3:0]    req_id;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [3:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic [7:0]    err_cnt;

  always #5 tb_clk = ~tb_clk;

  tb_req_responder #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .FIFO_DEPTH(FD)) dut (
    .tb_clk(tb_clk), .tb_rst(tb_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_id(req_id),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  st;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        log_q[$];
  logic [31:0] m_regs [NR];
  int          m_err = 0;
  bit          m_acc = 0;
  bit          last_rst = 1;
  bit          chk_on = 1;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Compare process: DUT outputs after each rising edge against the model.
  always @(negedge tb_clk) begin
    if (chk_on) begin
      chk("req_ready", 64'(req_ready), 64'(!tb_rst && (exp_q.size() < FD)));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
        chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
        chk("rsp_status", 64'(rsp_status), 64'(exp_q[0].st));
      end else if (last_rst) begin
        chk("rst_rsp_fields", 64'({rsp_id, rsp_data, rsp_status}), 64'(0));
      end
      chk("err_cnt", 64'(err_cnt), 64'(m_err));
    end
  end

  // Drives one cycle of inputs and advances the model to the state after the next edge.
  task automatic cycle(input bit rst, input bit v, input logic [1:0] op, input logic [3:0] id,
                       input logic [3:0] a, input logic [31:0] d, input bit rr);
    rsp_t e;
    bit   rdy;
    bit   do_pop;
    @(negedge tb_clk);
    #1;
    tb_rst = rst; req_valid = v; req_op = op; req_id = id;
    req_addr = a; req_data = d; rsp_ready = rr;
    last_rst = rst;
    m_acc = 0;
    if (rst) begin
      exp_q.delete();
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_err = 0;
    end else begin
      rdy    = exp_q.size() < FD;
      do_pop = (exp_q.size() > 0) && rr;
      if (v && rdy) begin
        m_acc = 1;
        e.id = id; e.data = 32'h0; e.st = 2'b00;
        if (op == 2'b11) e.st = 2'b01;
        else if (int'(a) >= NR) e.st = ST_OOR;
        else begin
          case (op)
            2'b00: e.data = m_regs[a];
            2'b01: begin m_regs[a] = d; e.data = d; end
            default: begin e.data = m_regs[a]; m_regs[a] = m_regs[a] + 32'h1; end
          endcase
        end
        if (e.st != 2'b00 && m_err < 255) m_err++;
      end
      if (do_pop) log_q.push_back(exp_q.pop_front());
      if (m_acc) exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(0, 0, 2'b00, 4'h0, 4'h0, 32'h0, rr);
  endtask

  task automatic chk_log(input int idx, input logic [3:0] id, input logic [31:0] d, input logic [1:0] st);
    if (idx < log_q.size()) begin
      chk("log_id", 64'(log_q[idx].id), 64'(id));
      chk("log_data", 64'(log_q[idx].data), 64'(d));
      chk("log_status", 64'(log_q[idx].st), 64'(st));
    end else begin
      chk("log_present", 64'(log_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    int acc;
    int nid;
    bit got;
    foreach (m_regs[i]) m_regs[i] = 32'h0;
    tb_rst = 1; req_valid = 0; req_op = 0; req_id = 0; req_addr = 0; req_data = 0; rsp_ready = 0;
    cycle(1, 0, 2'b00, 4'h0, 4'h0, 32'h0, 0);
    cycle(1, 1, 2'b01, 4'h0, 4'h3, 32'h1111, 0);

    // Write then read back.
    log_q.delete();
    cycle(0, 1, 2'b01, 4'h0, 4'h3, 32'hDEADBEEF, 1);
    cycle(0, 1, 2'b00, 4'h1, 4'h3, 32'h0, 1);
    idle(4, 1);
    chk("seq_wr_rd_n", 64'(log_q.size()), 64'(2));
    chk_log(0, 4'h0, 32'hDEADBEEF, 2'b00);
    chk_log(1, 4'h1, 32'hDEADBEEF, 2'b00);

    // Increment wraps to zero.
    log_q.delete();
    cycle(0, 1, 2'b01, 4'h2, 4'h5, 32'hFFFFFFFF, 1);
    cycle(0, 1, 2'b10, 4'h3, 4'h5, 32'h0, 1);
    cycle(0, 1, 2'b00, 4'h4, 4'h5, 32'h0, 1);
    idle(4, 1);
    chk_log(0, 4'h2, 32'hFFFFFFFF, 2'b00);
    chk_log(1, 4'h3, 32'hFFFFFFFF, 2'b00);
    chk_log(2, 4'h4, 32'h00000000, 2'b00);

    // Backpressure: four fit, the fifth waits for a pop.
    log_q.delete();
    acc = 0; nid = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, 2'b00, 4'(nid), 4'h3, 32'h0, 0);
      if (m_acc) begin acc++; nid++; end
    end
    chk("full_accepts", 64'(acc), 64'(4));
    chk("full_ready", 64'(req_ready), 64'(0));
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      cycle(0, 1, 2'b00, 4'(nid), 4'h3, 32'h0, 1);
      got = m_acc;
    end
    chk("fifth_accepted", 64'(got), 64'(1));
    idle(8, 1);
    chk("bp_resp_n", 64'(log_q.size()), 64'(5));
    for (int i = 0; i < 5; i++) chk_log(i, 4'(i), 32'hDEADBEEF, 2'b00);

    // Illegal op and err_cnt saturation.
    log_q.delete();
    cycle(0, 1, 2'b11, 4'hA, 4'h0, 32'h1234, 1);
    idle(3, 1);
    chk_log(0, 4'hA, 32'h0, 2'b01);
    chk("err_one", 64'(err_cnt), 64'(1));
    for (int i = 0; i < 300; i++) cycle(0, 1, 2'b11, 4'(i), 4'h0, 32'h0, 1);
    idle(3, 1);
    chk("err_sat", 64'(err_cnt), 64'(255));

    // Out-of-range address.
    log_q.delete();
    cycle(0, 1, 2'b00, 4'h5, 4'hD, 32'h0, 1);
    cycle(0, 1, 2'b01, 4'h6, 4'hD, 32'h55, 1);
    cycle(0, 1, 2'b00, 4'h7, 4'hD, 32'h0, 1);
    idle(4, 1);
    chk_log(0, 4'h5, 32'h0, ST_OOR);
    chk_log(1, 4'h6, 32'h0, ST_OOR);
    chk_log(2, 4'h7, 32'h0, ST_OOR);

    // Reset with responses queued.
    cycle(0, 1, 2'b01, 4'h8, 4'h1, 32'h1234, 0);
    cycle(0, 1, 2'b00, 4'h9, 4'h1, 32'h0, 0);
    cycle(0, 1, 2'b00, 4'hA, 4'h3, 32'h0, 0);
    cycle(1, 1, 2'b00, 4'hB, 4'h1, 32'h0, 0);
    cycle(0, 0, 2'b00, 4'h0, 4'h0, 32'h0, 1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    log_q.delete();
    cycle(0, 1, 2'b00, 4'h9, 4'h1, 32'h0, 1);
    cycle(0, 1, 2'b00, 4'hA, 4'h3, 32'h0, 1);
    idle(4, 1);
    chk_log(0, 4'h9, 32'h0, 2'b00);
    chk_log(1, 4'hA, 32'h0, 2'b00);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom),
            ($urandom_range(0, 2) != 0));
    end
    idle(10, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
